// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C Wishbone front end.
// Holds the bus data width, the register address map, and the bit positions
// inside the CTRL and STATUS registers. It is used by i2c_sync_fifo and
// i2c_wb_fifo_if.
package i2c_pkg;

    localparam int DATA_W = 8;

    // Register map, decoded from the low three address bits.
    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_STATUS    = 3'd1;
    localparam logic [2:0] ADDR_DATA      = 3'd2;
    localparam logic [2:0] ADDR_TX_LEVEL  = 3'd3;
    localparam logic [2:0] ADDR_RX_LEVEL  = 3'd4;
    localparam logic [2:0] ADDR_RX_THRESH = 3'd5;
    localparam logic [2:0] ADDR_SLAVE_ADD = 3'd6;
    localparam logic [2:0] ADDR_PRESCALE  = 3'd7;

    // CTRL bit positions. TX_FLUSH and RX_FLUSH are write-1 strobes that
    // always read back as 0.
    localparam int CTRL_CORE_EN   = 0;
    localparam int CTRL_INTER_EN  = 1;
    localparam int CTRL_MODE      = 2;
    localparam int CTRL_MASTER_RW = 3;
    localparam int CTRL_ACK       = 4;
    localparam int CTRL_REP_START = 5;
    localparam int CTRL_TX_FLUSH  = 6;
    localparam int CTRL_RX_FLUSH  = 7;

    // STATUS bit positions. Bits 4..6 are sticky and write-1-to-clear.
    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_RX_OVF   = 4;
    localparam int ST_TX_OVF   = 5;
    localparam int ST_ARB_LOST = 6;
    localparam int ST_IRQ      = 7;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Synchronous byte FIFO used for the TX and RX paths.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   push, din      write request and data; dropped when full
//   pop            read request; ignored when empty
//   flush          empties the FIFO; overrides push and pop on the same edge
//   dout           head entry, combinational
//   level          number of stored entries (0..DEPTH)
//   full, empty    derived from the current (pre-edge) level
module i2c_sync_fifo
    import i2c_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [LW-1:0]     level,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage is data only; its contents are meaningless while level is 0.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/i2c_wb_fifo_if.sv
// Wishbone front end for the byte-level I2C core with TX/RX FIFOs.
// Ports:
//   wb_*                8-bit Wishbone slave, one wait state per access
//   irq                 registered, maskable level interrupt
//   core_en, mode, master_rw, ack, rep_start
//                       CTRL register fields driven to the core
//   slave_add, prescale configuration registers
//   tx_byte/tx_valid/tx_ready
//                       TX FIFO head offered to the core (valid/ready)
//   rx_byte/rx_valid    RX bytes from the core, one-cycle valid pulses
//   arb_lost            arbitration-lost indication from the core
module i2c_wb_fifo_if
    import i2c_pkg::*;
#(
    parameter int         DEPTH        = 8,
    parameter int         LW           = $clog2(DEPTH + 1),
    parameter logic [7:0] RST_PRESCALE = 8'h00
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [7:0] wb_add_i,
    input  logic [7:0] wb_data_i,
    output logic [7:0] wb_data_o,
    input  logic       wb_we_i,
    input  logic       wb_stb_i,
    input  logic       wb_cyc_i,
    output logic       wb_ack_o,
    output logic       irq,
    output logic       core_en,
    output logic       mode,
    output logic       master_rw,
    output logic       ack,
    output logic       rep_start,
    output logic [7:0] slave_add,
    output logic [7:0] prescale,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       arb_lost
);

    logic [5:0]    ctrl_q;
    logic [7:0]    rx_thresh_q;
    logic [7:0]    slave_add_q;
    logic [7:0]    prescale_q;
    logic          rx_ovf_q;
    logic          tx_ovf_q;
    logic          arb_q;
    logic          irq_q;

    logic          acc;
    logic          addr_ok;
    logic [2:0]    sel;
    logic          wr;
    logic          rd;
    logic          ctrl_wr;
    logic          status_wr;
    logic          data_wr;
    logic          data_rd;
    logic          en_drop;
    logic          tx_flush;
    logic          rx_flush;
    logic          tx_pop;

    logic [7:0]    rx_dout;
    logic [LW-1:0] tx_level;
    logic [LW-1:0] rx_level;
    logic          tx_full;
    logic          tx_empty;
    logic          rx_full;
    logic          rx_empty;

    logic [7:0]    status_vec;
    logic [7:0]    rd_mux;
    logic          irq_cause;

    // Access strobe: true only on the edge that raises the ack, so every
    // side effect fires exactly once per bus access.
    assign acc       = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign addr_ok   = (wb_add_i[7:3] == 5'd0);
    assign sel       = wb_add_i[2:0];
    assign wr        = acc & wb_we_i & addr_ok;
    assign rd        = acc & ~wb_we_i & addr_ok;
    assign ctrl_wr   = wr & (sel == ADDR_CTRL);
    assign status_wr = wr & (sel == ADDR_STATUS);
    assign data_wr   = wr & (sel == ADDR_DATA);
    assign data_rd   = rd & (sel == ADDR_DATA);

    // Disabling the core discards anything queued in either direction.
    assign en_drop  = ctrl_wr & ctrl_q[CTRL_CORE_EN] & ~wb_data_i[CTRL_CORE_EN];
    assign tx_flush = (ctrl_wr & wb_data_i[CTRL_TX_FLUSH]) | en_drop;
    assign rx_flush = (ctrl_wr & wb_data_i[CTRL_RX_FLUSH]) | en_drop;

    assign tx_valid = ~tx_empty & ctrl_q[CTRL_CORE_EN];
    assign tx_pop   = tx_valid & tx_ready;

    i2c_sync_fifo #(.DEPTH(DEPTH), .LW(LW)) u_tx_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (data_wr),
        .pop   (tx_pop),
        .flush (tx_flush),
        .din   (wb_data_i),
        .dout  (tx_byte),
        .level (tx_level),
        .full  (tx_full),
        .empty (tx_empty)
    );

    i2c_sync_fifo #(.DEPTH(DEPTH), .LW(LW)) u_rx_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (rx_valid),
        .pop   (data_rd),
        .flush (rx_flush),
        .din   (rx_byte),
        .dout  (rx_dout),
        .level (rx_level),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign status_vec = {irq_q, arb_q, tx_ovf_q, rx_ovf_q,
                         rx_full, rx_empty, tx_full, tx_empty};

    always_comb begin
        rd_mux = '0;
        case (sel)
            ADDR_CTRL:      rd_mux = {2'b00, ctrl_q};
            ADDR_STATUS:    rd_mux = status_vec;
            ADDR_DATA:      rd_mux = rx_empty ? 8'h00 : rx_dout;
            ADDR_TX_LEVEL:  rd_mux = 8'(tx_level);
            ADDR_RX_LEVEL:  rd_mux = 8'(rx_level);
            ADDR_RX_THRESH: rd_mux = rx_thresh_q;
            ADDR_SLAVE_ADD: rd_mux = slave_add_q;
            ADDR_PRESCALE:  rd_mux = prescale_q;
            default:        rd_mux = '0;
        endcase
    end

    // A threshold of 0 disables the level-based interrupt source.
    assign irq_cause = rx_ovf_q | tx_ovf_q | arb_q |
                       ((rx_thresh_q != 8'h00) && (8'(rx_level) >= rx_thresh_q));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o    <= 1'b0;
            wb_data_o   <= '0;
            ctrl_q      <= '0;
            rx_thresh_q <= '0;
            slave_add_q <= '0;
            prescale_q  <= RST_PRESCALE;
            rx_ovf_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            arb_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            wb_ack_o <= acc;
            if (acc && !wb_we_i) wb_data_o <= addr_ok ? rd_mux : 8'h00;

            if (ctrl_wr) ctrl_q <= wb_data_i[5:0];
            if (wr && sel == ADDR_RX_THRESH) rx_thresh_q <= wb_data_i;
            if (wr && sel == ADDR_SLAVE_ADD) slave_add_q <= wb_data_i;
            if (wr && sel == ADDR_PRESCALE)  prescale_q  <= wb_data_i;

            // Sticky flags: a new event on the same edge beats the W1C.
            rx_ovf_q <= (rx_ovf_q & ~(status_wr & wb_data_i[ST_RX_OVF]))
                        | (rx_valid & rx_full);
            tx_ovf_q <= (tx_ovf_q & ~(status_wr & wb_data_i[ST_TX_OVF]))
                        | (data_wr & tx_full);
            arb_q    <= (arb_q & ~(status_wr & wb_data_i[ST_ARB_LOST]))
                        | arb_lost;

            irq_q <= ctrl_q[CTRL_INTER_EN] & irq_cause;
        end
    end

    assign irq       = irq_q;
    assign core_en   = ctrl_q[CTRL_CORE_EN];
    assign mode      = ctrl_q[CTRL_MODE];
    assign master_rw = ctrl_q[CTRL_MASTER_RW];
    assign ack       = ctrl_q[CTRL_ACK];
    assign rep_start = ctrl_q[CTRL_REP_START];
    assign slave_add = slave_add_q;
    assign prescale  = prescale_q;

endmodule

// File: tb/tb_i2c_wb_fifo_if.sv
// Self-checking bench for i2c_wb_fifo_if: directed scenarios followed by a
// randomized mix of bus and core traffic, compared against a queue-based
// reference model.
module tb_i2c_wb_fifo_if;

    localparam int         DEPTH = 8;
    localparam logic [7:0] RSTP  = 8'h5A;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wb_add;
    logic [7:0] wb_dat_w;
    logic [7:0] wb_dat_r;
    logic       wb_we;
    logic       wb_stb;
    logic       wb_cyc;
    logic       wb_ack;
    logic       irq;
    logic       core_en;
    logic       mode;
    logic       master_rw;
    logic       ack_bit;
    logic       rep_start;
    logic [7:0] slave_add;
    logic [7:0] prescale;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       arb_lost;

    always #5 clk = ~clk;

    i2c_wb_fifo_if #(.DEPTH(DEPTH), .RST_PRESCALE(RSTP)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb_add_i  (wb_add),
        .wb_data_i (wb_dat_w),
        .wb_data_o (wb_dat_r),
        .wb_we_i   (wb_we),
        .wb_stb_i  (wb_stb),
        .wb_cyc_i  (wb_cyc),
        .wb_ack_o  (wb_ack),
        .irq       (irq),
        .core_en   (core_en),
        .mode      (mode),
        .master_rw (master_rw),
        .ack       (ack_bit),
        .rep_start (rep_start),
        .slave_add (slave_add),
        .prescale  (prescale),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .arb_lost  (arb_lost)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [5:0] m_ctrl;
    logic [7:0] m_thr, m_sla, m_pre;
    bit         m_rxovf, m_txovf, m_arb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_irq();
        return m_ctrl[1] & (m_rxovf | m_txovf | m_arb |
                            ((m_thr != 8'h00) && (rx_q.size() >= int'(m_thr))));
    endfunction

    function automatic logic [7:0] m_status();
        return {m_irq(), 1'(m_arb), 1'(m_txovf), 1'(m_rxovf),
                1'(rx_q.size() == DEPTH), 1'(rx_q.size() == 0),
                1'(tx_q.size() == DEPTH), 1'(tx_q.size() == 0)};
    endfunction

    function automatic logic [7:0] m_reg(input logic [7:0] a);
        case (a)
            8'd0:    return {2'b00, m_ctrl};
            8'd1:    return m_status();
            8'd3:    return 8'(tx_q.size());
            8'd4:    return 8'(rx_q.size());
            8'd5:    return m_thr;
            8'd6:    return m_sla;
            8'd7:    return m_pre;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_ctrl = '0; m_thr = '0; m_sla = '0; m_pre = RSTP;
        m_rxovf = 0; m_txovf = 0; m_arb = 0;
    endtask

    // One Wishbone access; tx_ready / rx_valid are held only for the ack edge.
    task automatic xfer(input logic [7:0] a, input logic [7:0] d, input logic w,
                        input logic rdy, input logic rxv, input logic [7:0] rxb,
                        output logic [7:0] rdata);
        int n;
        @(posedge clk); #1;
        wb_add = a; wb_dat_w = d; wb_we = w; wb_stb = 1'b1; wb_cyc = 1'b1;
        tx_ready = rdy; rx_valid = rxv; rx_byte = rxb;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb_ack && n < 8);
        check("ack_latency", n, 1);
        rdata = wb_dat_r;
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d, input logic rdy,
                             input logic rxv, input logic [7:0] rxb);
        logic [7:0] unused_rd;
        bit tx_was_full, rx_was_full, do_txpop, txfl, rxfl;
        tx_was_full = (tx_q.size() == DEPTH);
        rx_was_full = (rx_q.size() == DEPTH);
        do_txpop    = rdy && m_ctrl[0] && (tx_q.size() > 0);
        txfl = (a == 8'd0) && (d[6] || (m_ctrl[0] && !d[0]));
        rxfl = (a == 8'd0) && (d[7] || (m_ctrl[0] && !d[0]));
        xfer(a, d, 1'b1, rdy, rxv, rxb, unused_rd);
        if (a == 8'd1) begin
            if (d[4]) m_rxovf = 0;
            if (d[5]) m_txovf = 0;
            if (d[6]) m_arb = 0;
        end
        if (do_txpop) void'(tx_q.pop_front());
        if (a == 8'd2) begin
            if (tx_was_full) m_txovf = 1;
            else tx_q.push_back(d);
        end
        if (rxv) begin
            if (rx_was_full) m_rxovf = 1;
            else rx_q.push_back(rxb);
        end
        if (txfl) tx_q.delete();
        if (rxfl) rx_q.delete();
        case (a)
            8'd0: m_ctrl = d[5:0];
            8'd5: m_thr = d;
            8'd6: m_sla = d;
            8'd7: m_pre = d;
            default: ;
        endcase
    endtask

    task automatic chk_read(input logic [7:0] a, input string tag);
        logic [7:0] exp, got;
        if (a == 8'd2) exp = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        else           exp = m_reg(a);
        xfer(a, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, got);
        if (a == 8'd2 && rx_q.size() > 0) void'(rx_q.pop_front());
        check(tag, got, exp);
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_byte = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        if (rx_q.size() == DEPTH) m_rxovf = 1;
        else rx_q.push_back(b);
    endtask

    task automatic chk_irq(input string tag);
        @(posedge clk); #1;
        check(tag, irq, m_irq());
    endtask

    task automatic tx_drain(input string tag);
        int n;
        n = tx_q.size();
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, tx_valid, 1);
            check({tag, "_byte"}, tx_byte, tx_q[0]);
            @(posedge clk); #1;
            void'(tx_q.pop_front());
        end
        tx_ready = 1'b0;
        check({tag, "_done"}, tx_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wb_add = '0; wb_dat_w = '0; wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
        tx_ready = 1'b0; rx_byte = '0; rx_valid = 1'b0; arb_lost = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", wb_ack, 0);
        check("rst_data", wb_dat_r, 0);
        check("rst_irq", irq, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_prescale_port", prescale, RSTP);
        rst = 1'b0;

        // Register reads after reset, plus out-of-range addresses.
        for (int a = 0; a < 8; a++) chk_read(8'(a), "rst_reg");
        @(posedge clk); #1;
        check("ack_single", wb_ack, 0);
        chk_read(8'h1E, "high_addr_read");
        bus_write(8'h0E, 8'h77, 0, 0, 8'h00);
        chk_read(8'd6, "high_addr_write_ignored");

        // CTRL fields reach the core outputs.
        bus_write(8'd0, 8'h3D, 0, 0, 8'h00);
        check("ctrl_fields", {rep_start, ack_bit, master_rw, mode, core_en}, 5'h1F);
        chk_read(8'd0, "ctrl_read");
        bus_write(8'd6, 8'hC4, 0, 0, 8'h00);
        bus_write(8'd7, 8'h3B, 0, 0, 8'h00);
        check("slave_add_port", slave_add, 8'hC4);
        check("prescale_port", prescale, 8'h3B);

        // Fill TX, overflow it, then drain it through the core handshake.
        for (int i = 1; i <= 8; i++) bus_write(8'd2, 8'(8'hA0 + i), 0, 0, 8'h00);
        chk_read(8'd3, "tx_level_full");
        chk_read(8'd1, "tx_full_status");
        bus_write(8'd2, 8'hFF, 0, 0, 8'h00);
        chk_read(8'd1, "tx_ovf_status");
        chk_read(8'd3, "tx_level_after_ovf");
        tx_drain("tx_drain");
        bus_write(8'd1, 8'h20, 0, 0, 8'h00);

        // RX threshold interrupt.
        bus_write(8'd5, 8'd3, 0, 0, 8'h00);
        bus_write(8'd0, 8'h03, 0, 0, 8'h00);
        rx_pulse(8'h11); chk_irq("irq_lvl1");
        rx_pulse(8'h22); chk_irq("irq_lvl2");
        rx_pulse(8'h33);
        check("irq_not_early", irq, 0);
        @(posedge clk); #1;
        check("irq_rise", irq, 1);
        chk_read(8'd2, "rx_read1");
        chk_irq("irq_fall");
        chk_read(8'd2, "rx_read2");
        chk_read(8'd2, "rx_read3");
        chk_read(8'd2, "rx_read_empty");

        // RX overflow and W1C.
        for (int i = 0; i < 8; i++) rx_pulse(8'($urandom));
        rx_pulse(8'hEE);
        chk_read(8'd1, "rx_ovf_status");
        chk_irq("rx_ovf_irq");
        bus_write(8'd1, 8'h10, 0, 0, 8'h00);
        chk_read(8'd1, "rx_ovf_cleared");
        chk_irq("irq_hold_level");
        for (int i = 0; i < 8; i++) chk_read(8'd2, "rx_drain");

        // Simultaneous TX push and core pop at level 4.
        for (int i = 1; i <= 4; i++) bus_write(8'd2, 8'(8'hB0 + i), 0, 0, 8'h00);
        bus_write(8'd2, 8'hB5, 1, 0, 8'h00);
        chk_read(8'd3, "tx_level_pushpop");
        tx_drain("tx_order_pushpop");

        // RX flush wins over a same-edge RX push; then arb_lost.
        rx_pulse(8'h5C); rx_pulse(8'h6D);
        bus_write(8'd0, 8'h81, 0, 1, 8'h7E);
        chk_read(8'd4, "rx_flush_level");
        chk_read(8'd0, "ctrl_flush_reads0");
        bus_write(8'd0, 8'h03, 0, 0, 8'h00);
        @(posedge clk); #1; arb_lost = 1'b1;
        @(posedge clk); #1; arb_lost = 1'b0;
        m_arb = 1;
        chk_read(8'd1, "arb_status");
        chk_irq("arb_irq");
        arb_lost = 1'b1;
        bus_write(8'd1, 8'h40, 0, 0, 8'h00);
        m_arb = 1;
        arb_lost = 1'b0;
        chk_read(8'd1, "arb_set_wins");
        bus_write(8'd1, 8'h40, 0, 0, 8'h00);
        chk_read(8'd1, "arb_cleared");
        chk_irq("arb_irq_fall");

        // Disabling the core empties both FIFOs.
        bus_write(8'd2, 8'h91, 0, 0, 8'h00);
        rx_pulse(8'h92);
        bus_write(8'd0, 8'h02, 0, 0, 8'h00);
        chk_read(8'd3, "en_drop_tx_level");
        chk_read(8'd4, "en_drop_rx_level");
        bus_write(8'd0, 8'h03, 0, 0, 8'h00);

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0, 1: bus_write(8'd2, 8'($urandom), 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 1)), 8'($urandom));
                2: chk_read(8'd2, "rnd_data");
                3: rx_pulse(8'($urandom));
                4: chk_read(8'd1, "rnd_status");
                5: chk_read(8'($urandom_range(3, 4)), "rnd_level");
                6: bus_write(8'd1, 8'($urandom), 0, 0, 8'h00);
                7: begin
                    if ($urandom_range(0, 3) == 0)
                        bus_write(8'd0, {2'($urandom), 4'($urandom), 2'b11}, 0, 0, 8'h00);
                    else
                        chk_read(8'($urandom_range(5, 15)), "rnd_reg");
                end
                8: bus_write(8'd5, 8'($urandom_range(0, 9)), 0, 0, 8'h00);
                default: bus_write(8'($urandom_range(6, 7)), 8'($urandom), 0, 0, 8'h00);
            endcase
            if (k % 16 == 15) chk_irq("rnd_irq");
        end

        // Reset in the middle of an access with both FIFOs populated.
        bus_write(8'd0, 8'h03, 0, 0, 8'h00);
        bus_write(8'd2, 8'h44, 0, 0, 8'h00);
        rx_pulse(8'h55);
        @(posedge clk); #1;
        wb_add = 8'd2; wb_dat_w = 8'h66; wb_we = 1'b1; wb_stb = 1'b1; wb_cyc = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_ack", wb_ack, 0);
        check("midrst_tx_valid", tx_valid, 0);
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        rst = 1'b0;
        model_reset();
        chk_read(8'd1, "midrst_status");
        chk_read(8'd3, "midrst_tx_level");
        chk_read(8'd4, "midrst_rx_level");
        chk_read(8'd7, "midrst_prescale");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
